// File: rtl/hub75_pkg.sv
// Shared types and default parameters for the HUB75 scan controller.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_BLANK,
    ST_LATCH,
    ST_SHOW
  } state_t;

  localparam int DEF_COLS     = 64;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_CH       = 2;
  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_LSB_ON   = 8;

endpackage

// File: rtl/hub75_gamma_lut.sv
// Registered gamma-2.8 lookup for one colour component; compiled only when GAMMA_EN is defined.
`ifdef GAMMA_EN
module hub75_gamma_lut #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] data_i,
  output logic [BITS-1:0] data_o
);

  // Table contents are fixed at elaboration; real math never reaches hardware.
  function automatic int gamma_entry(input int idx);
    real max_v;
    real x;
    max_v = real'((1 << BITS) - 1);
    x     = real'(idx) / max_v;
    return $rtoi(max_v * (x ** 2.8) + 0.5);
  endfunction

  logic [BITS-1:0] lut [1 << BITS];
  logic [BITS-1:0] data_d;
  logic [BITS-1:0] data_q;

  for (genvar gi = 0; gi < (1 << BITS); gi++) begin : g_entry
    assign lut[gi] = BITS'(gamma_entry(gi));
  end

  always_comb data_d = lut[data_i];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end

  assign data_o = data_q;

endmodule
`endif

// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED panel scan controller: shifts bit-planes row by row with BCM display windows.
// Optional gamma correction of every component is enabled by defining GAMMA_EN.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CH       = DEF_CH,
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int LSB_ON   = DEF_LSB_ON
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             display_ena,
  input  logic [3:0]                       brightness,
  input  logic [CH*3*PWM_BITS-1:0]         ram_data,
  output logic [ADDR_W+$clog2(COLS)-1:0]   ram_address,
  output logic [CH*3-1:0]                  display_rgb,
  output logic [ADDR_W-1:0]                d_addr,
  output logic                             d_clk,
  output logic                             d_lat,
  output logic                             d_oe,
  output logic                             frame_start
);

  localparam int CW       = $clog2(COLS);
  localparam int PW       = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1;
  localparam int SHOW_MAX = LSB_ON << (PWM_BITS - 1);
  localparam int SW       = $clog2(SHOW_MAX + 1);
  localparam int TW       = $clog2(((CLK_DIV > SHOW_MAX) ? CLK_DIV : SHOW_MAX) + 1);

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [CW-1:0]    col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [PW-1:0]    plane_q, plane_d;
  logic [SW-1:0]    on_len_q, on_len_d;
  logic [CH*3-1:0]  display_rgb_q, display_rgb_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic             frame_start_q, frame_start_d;

  logic [CH*3-1:0]  rgb_bits;
  logic [SW-1:0]    show_len;
  logic [SW+3:0]    prod;
  logic [SW-1:0]    on_calc;
  logic             div_last, show_last, col_last, plane_last, row_last;

  // Each component selects its bit for the current plane, optionally after the gamma LUT.
  for (genvar gi = 0; gi < CH*3; gi++) begin : g_comp
    logic [PWM_BITS-1:0] comp;
`ifdef GAMMA_EN
    hub75_gamma_lut #(.BITS(PWM_BITS)) u_gamma (
      .clk    (clk),
      .rst    (rst),
      .data_i (ram_data[gi*PWM_BITS +: PWM_BITS]),
      .data_o (comp)
    );
`else
    assign comp = ram_data[gi*PWM_BITS +: PWM_BITS];
`endif
    assign rgb_bits[gi] = comp[plane_q];
  end

  always_comb begin
    show_len   = SW'(LSB_ON) << plane_q;
    prod       = (SW+4)'(show_len) * (SW+4)'(brightness) + (SW+4)'(show_len);
    on_calc    = SW'(prod >> 4);
    div_last   = (tick_q == TW'(CLK_DIV - 1));
    show_last  = (tick_q == TW'(show_len) - TW'(1));
    col_last   = (col_q == CW'(COLS - 1));
    plane_last = (plane_q == PW'(PWM_BITS - 1));
    row_last   = &row_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (display_ena) state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (div_last) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (div_last) state_d = col_last ? ST_BLANK : ST_SHIFT_LO;
      ST_BLANK:    state_d = ST_LATCH;
      ST_LATCH:    if (div_last) state_d = ST_SHOW;
      ST_SHOW:     if (show_last) state_d = display_ena ? ST_SHIFT_LO : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tick_d        = (state_d != state_q || state_q == ST_IDLE) ? '0 : tick_q + TW'(1);
    col_d         = col_q;
    row_d         = row_q;
    plane_d       = plane_q;
    on_len_d      = on_len_q;
    display_rgb_d = display_rgb_q;
    d_addr_d      = d_addr_q;
    frame_start_d = 1'b0;
    if (state_q == ST_IDLE && display_ena) frame_start_d = 1'b1;
    if (state_q == ST_SHIFT_LO && div_last) display_rgb_d = rgb_bits;
    if (state_q == ST_SHIFT_HI && div_last) col_d = col_q + CW'(1);
    if (state_q == ST_BLANK) d_addr_d = row_q;
    if (state_q == ST_LATCH && div_last) on_len_d = (on_calc == '0) ? SW'(1) : on_calc;
    if (state_q == ST_SHOW && show_last) begin
      if (!display_ena) begin
        // Stopping always rewinds so a later enable starts a fresh frame.
        plane_d = '0;
        row_d   = '0;
      end else begin
        plane_d = plane_last ? '0 : plane_q + PW'(1);
        if (plane_last) row_d = row_q + ADDR_W'(1);
        frame_start_d = plane_last && row_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q        <= '0;
      col_q         <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      on_len_q      <= '0;
      display_rgb_q <= '0;
      d_addr_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      col_q         <= col_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      on_len_q      <= on_len_d;
      display_rgb_q <= display_rgb_d;
      d_addr_q      <= d_addr_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Panel strobes decode straight from state so reset blanks the panel immediately.
  always_comb begin
    d_clk = 1'b0;
    d_lat = 1'b0;
    d_oe  = 1'b1;
    case (state_q)
      ST_SHIFT_HI: d_clk = 1'b1;
      ST_LATCH:    d_lat = 1'b1;
      ST_SHOW:     d_oe  = !(tick_q < TW'(on_len_q));
      default:     ;
    endcase
  end

  assign ram_address = {row_q, col_q};
  assign display_rgb = display_rgb_q;
  assign d_addr      = d_addr_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 Parameter COLS, default 64, columns shifted per scan row (power of 2, >=2).
REQ-002 Parameter ADDR_W, default 4, row-address width; 2^ADDR_W scan rows.
REQ-003 Parameter CH, default 2, parallel RGB lanes (upper/lower half-panels).
REQ-004 Parameter PWM_BITS, default 8, colour depth per component; one bit-plane per bit.
REQ-005 Parameter CLK_DIV, default 2, clk cycles per d_clk half-period; >=2, >=3 when GAMMA_EN defined.
REQ-006 Parameter LSB_ON, default 8, display-window cycles of bit-plane 0.
REQ-007 clk  in  1  sole clock, all logic on rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 display_ena  in  1  run request, level.
REQ-010 brightness  in  4  global dimming, sampled at each SHOW entry.
REQ-011 ram_data  in  CH*3*PWM_BITS  pixel word, lane k = {B,G,R} at [k*3*PWM_BITS +: 3*PWM_BITS], valid 1 cycle after ram_address.
REQ-012 ram_address  out  ADDR_W+log2(COLS)  {row, column} of pixel being fetched.
REQ-013 display_rgb  out  CH*3  current bit-plane bits, lane k = {B,G,R} at [3k +: 3].
REQ-014 d_addr  out  ADDR_W;  d_clk, d_lat, d_oe  out  1 each; d_oe high = panel blanked.
REQ-015 frame_start  out  1  one-cycle pulse when row 0, plane 0 shifting begins.

Function
REQ-016 FSM states IDLE, SHIFT_LO, SHIFT_HI, BLANK, LATCH, SHOW; each of SHIFT_LO, SHIFT_HI, LATCH lasts exactly CLK_DIV cycles.
REQ-017 IDLE -> SHIFT_LO when display_ena=1; row, column, plane counters start at 0.
REQ-018 SHIFT_LO: d_clk=0, ram_address={row,col} from its first cycle; SHIFT_HI: d_clk=1, display_rgb updated on its first cycle, held to next SHIFT_HI.
REQ-019 display_rgb bit = bit [plane] of the (gamma-mapped) component for that column.
REQ-020 SHIFT_HI -> SHIFT_LO with col+1 while col<COLS-1; at col=COLS-1 -> BLANK, col wraps to 0.
REQ-021 BLANK: one cycle, d_oe=1, d_addr<=row; LATCH: d_lat=1, d_oe=1.
REQ-022 SHOW lasts (LSB_ON<<plane) cycles; d_oe=0 for first max(1, ((LSB_ON<<plane)*(brightness+1))>>4) cycles, 1 for the remainder.
REQ-023 After SHOW: plane+1 -> SHIFT_LO same row; at plane=PWM_BITS-1 plane wraps, row+1; at last row row wraps to 0, frame_start pulses on next SHIFT_LO entry.
REQ-024 display_ena=0 mid-frame: current plane completes through SHOW, then IDLE with d_oe=1; re-enable restarts at row 0, plane 0.
REQ-025 Counter widths exact; all wraps modulo range, no overflow into adjacent fields of ram_address.

Reset
REQ-026 rst low: state=IDLE, counters 0, ram_address=0, display_rgb=0, d_addr=0, d_clk=0, d_lat=0, d_oe=1, frame_start=0, immediately and asynchronously.
REQ-027 Reset mid-SHOW blanks the panel without waiting for the window end.

Configuration
REQ-028 GAMMA_EN defined: every component passes through a registered gamma LUT (gamma 2.8, PWM_BITS in/out), adding one cycle; display_rgb then updates on the second SHIFT_HI-relative fetch cycle, timing of d_clk unchanged.
REQ-029 GAMMA_EN undefined: raw ram_data bits used, no LUT instantiated.

Structure
REQ-030 Package hub75_pkg holds the state enum and default parameter constants.
REQ-031 Sub-module hub75_gamma_lut (one per component lane, CH*3 instances) exists only under GAMMA_EN.

Verification (COLS=4, ADDR_W=1, PWM_BITS=2, CLK_DIV=2, LSB_ON=4, brightness=15 unless noted)
REQ-032 Reset then display_ena=1 -> frame_start pulse, 4 d_clk rising edges, one d_lat pulse of 2 cycles, d_oe low 4 cycles (plane 0), then 8 cycles (plane 1).
REQ-033 Pixel R=2'b10 at row0 col2 -> display_rgb[0]=0 for plane 0, 1 for plane 1 at third d_clk rise.
REQ-034 brightness=0 -> plane 0 d_oe low 1 cycle of 4, plane 1 low 1 cycle of 8.
REQ-035 Run two frames -> d_addr sequence 0,0,1,1,0; frame_start exactly once per 2 rows x 2 planes.
REQ-036 display_ena dropped during row 1 plane 0 shift -> plane 0 SHOW completes, IDLE, d_oe=1; rst low mid-SHOW -> d_oe=1 same cycle.
